// File: rtl/lcd_panel_model_if.sv
// ============================================================================
//  Module      : lcd_panel_model_if
//  Description : E/RS/RW/DB character-LCD bus between driver (master) and panel.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface lcd_panel_model_if;
   logic       E;
   logic       RS;
   logic       RW;
   logic [7:0] DB;
   logic [7:0] db_out;
   logic       db_oe;

   modport master (output E, RS, RW, DB, input db_out, db_oe);
   modport slave  (input E, RS, RW, DB, output db_out, db_oe);
endinterface

`default_nettype wire

// File: rtl/lcd_panel_model.sv
// ============================================================================
//  Module      : lcd_panel_model
//  Description : HD44780-style panel responder with a 2x16 DDRAM image.
//                Define LCD_NIBBLE_EN to honour 4-bit transfers when DL=0.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lcd_panel_model #(
   parameter int BUSY_CYCLES = 1,
   parameter int BUSY_LONG   = 1
) (
   input  wire logic         clk,
   input  wire logic         reset,
   lcd_panel_model_if.slave  bus,
   input  wire logic [4:0]   rd_idx,
   output logic      [7:0]   rd_char,
   output logic      [6:0]   ac,
   output logic              busy,
   output logic              disp_on,
   output logic              cursor_on,
   output logic              blink_on,
   output logic              two_line,
   output logic              err_busy
);

   localparam int BUSY_MAX = (BUSY_LONG > BUSY_CYCLES) ? BUSY_LONG : BUSY_CYCLES;
   localparam int CNT_W    = (BUSY_MAX < 2) ? 1 : $clog2(BUSY_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_SHORT = CNT_W'(BUSY_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LONG  = CNT_W'(BUSY_LONG);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [7:0]       BLANK     = 8'h20;

   // DDRAM address walk: line 1 is 0x00-0x27, line 2 is 0x40-0x67
   function automatic logic [6:0] ac_step(input logic [6:0] a, input logic inc);
      logic [6:0] r;
      if (inc) begin
         if (a == 7'h27)      r = 7'h40;
         else if (a == 7'h67) r = 7'h00;
         else                 r = a + 7'd1;
      end else begin
         if (a == 7'h00)      r = 7'h67;
         else if (a == 7'h40) r = 7'h27;
         else                 r = a - 7'd1;
      end
      return r;
   endfunction

   logic             e_q, e_d;
   logic             rs_q, rs_d;
   logic             rw_q, rw_d;
   logic [7:0]       db_q, db_d;
   logic [6:0]       ac_q, ac_d;
   logic             id_q, id_d;
   logic             dl_q, dl_d;
   logic             disp_q, disp_d;
   logic             cursor_q, cursor_d;
   logic             blink_q, blink_d;
   logic             two_line_q, two_line_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       cells_q [32];
   logic [7:0]       cells_d [32];

   logic             w_fall;
   logic             w_busy;
   logic             w_vis;
   logic [4:0]       w_cell;
   logic             w_xfer;
   logic [7:0]       w_byte;
   logic [7:0]       w_rd_byte;
   logic [7:0]       w_rd_out;

`ifdef LCD_NIBBLE_EN
   logic             phase_q, phase_d;
   logic [3:0]       nib_q, nib_d;
`else
   logic             unused_dl;
   assign unused_dl = dl_q;
`endif

   assign w_fall = e_q & ~bus.E;
   assign w_busy = (cnt_q != '0);
   assign w_vis  = (ac_q[6:4] == 3'b000) || (ac_q[6:4] == 3'b100);
   assign w_cell = {ac_q[6], ac_q[3:0]};

   // Read path is combinational off the live strobe so data is valid during E high
   always_comb begin
      w_rd_byte = w_vis ? cells_q[w_cell] : BLANK;
      w_rd_out  = bus.RS ? w_rd_byte : {w_busy, ac_q};
`ifdef LCD_NIBBLE_EN
      if (!dl_q && phase_q) w_rd_out = {w_rd_out[3:0], 4'h0};
`endif
   end

   assign bus.db_oe  = reset & bus.E & bus.RW;
   assign bus.db_out = bus.db_oe ? w_rd_out : 8'h00;

   always_comb begin
      e_d        = bus.E;
      rs_d       = rs_q;
      rw_d       = rw_q;
      db_d       = db_q;
      if (bus.E) begin
         rs_d = bus.RS;
         rw_d = bus.RW;
         db_d = bus.DB;
      end
      ac_d       = ac_q;
      id_d       = id_q;
      dl_d       = dl_q;
      disp_d     = disp_q;
      cursor_d   = cursor_q;
      blink_d    = blink_q;
      two_line_d = two_line_q;
      err_d      = 1'b0;
      cells_d    = cells_q;
      cnt_d      = w_busy ? (cnt_q - CNT_ONE) : cnt_q;
      w_byte     = db_q;
      w_xfer     = w_fall;
`ifdef LCD_NIBBLE_EN
      phase_d    = phase_q;
      nib_d      = nib_q;
      if (w_fall && !dl_q) begin
         if (!phase_q) begin
            phase_d = 1'b1;
            nib_d   = db_q[7:4];
            w_xfer  = 1'b0;
         end else begin
            phase_d = 1'b0;
            w_byte  = {nib_q, db_q[7:4]};
         end
      end
`endif
      // A commit overrides the decrement so busy lasts exactly the loaded count
      if (w_xfer) begin
         if (rw_q) begin
            if (rs_q) ac_d = ac_step(ac_q, id_q);
         end else if (w_busy) begin
            err_d = 1'b1;
         end else if (rs_q) begin
            if (w_vis) cells_d[w_cell] = w_byte;
            ac_d  = ac_step(ac_q, id_q);
            cnt_d = CNT_SHORT;
         end else begin
            casez (w_byte)
               8'b1???????: begin
                  ac_d  = w_byte[6:0];
                  cnt_d = CNT_SHORT;
               end
               8'b01??????: cnt_d = CNT_SHORT;
               8'b001?????: begin
                  dl_d       = w_byte[4];
                  two_line_d = w_byte[3];
                  cnt_d      = CNT_SHORT;
               end
               8'b0001????: begin
                  if (!w_byte[3]) ac_d = ac_step(ac_q, w_byte[2]);
                  cnt_d = CNT_SHORT;
               end
               8'b00001???: begin
                  disp_d   = w_byte[2];
                  cursor_d = w_byte[1];
                  blink_d  = w_byte[0];
                  cnt_d    = CNT_SHORT;
               end
               8'b000001??: begin
                  id_d  = w_byte[1];
                  cnt_d = CNT_SHORT;
               end
               8'b0000001?: begin
                  ac_d  = 7'h00;
                  cnt_d = CNT_LONG;
               end
               8'b00000001: begin
                  for (int i = 0; i < 32; i++) cells_d[i] = BLANK;
                  ac_d  = 7'h00;
                  id_d  = 1'b1;
                  cnt_d = CNT_LONG;
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         e_q        <= 1'b0;
         rs_q       <= 1'b0;
         rw_q       <= 1'b0;
         db_q       <= 8'h00;
         ac_q       <= 7'h00;
         id_q       <= 1'b1;
         dl_q       <= 1'b1;
         disp_q     <= 1'b0;
         cursor_q   <= 1'b0;
         blink_q    <= 1'b0;
         two_line_q <= 1'b0;
         err_q      <= 1'b0;
         cnt_q      <= '0;
         for (int i = 0; i < 32; i++) cells_q[i] <= BLANK;
`ifdef LCD_NIBBLE_EN
         phase_q    <= 1'b0;
         nib_q      <= 4'h0;
`endif
      end else begin
         e_q        <= e_d;
         rs_q       <= rs_d;
         rw_q       <= rw_d;
         db_q       <= db_d;
         ac_q       <= ac_d;
         id_q       <= id_d;
         dl_q       <= dl_d;
         disp_q     <= disp_d;
         cursor_q   <= cursor_d;
         blink_q    <= blink_d;
         two_line_q <= two_line_d;
         err_q      <= err_d;
         cnt_q      <= cnt_d;
         cells_q    <= cells_d;
`ifdef LCD_NIBBLE_EN
         phase_q    <= phase_d;
         nib_q      <= nib_d;
`endif
      end
   end

   assign rd_char   = cells_q[rd_idx];
   assign ac        = ac_q;
   assign busy      = w_busy;
   assign disp_on   = disp_q;
   assign cursor_on = cursor_q;
   assign blink_on  = blink_q;
   assign two_line  = two_line_q;
   assign err_busy  = err_q;

endmodule

`default_nettype wire

// File: tb/tb_lcd_panel_model.sv
// ============================================================================
//  Module      : tb_lcd_panel_model
//  Description : Scoreboard bench for lcd_panel_model (directed vectors).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lcd_panel_model;

   localparam int BUSY_CYCLES = 4;
   localparam int BUSY_LONG   = 20;

   localparam int K_CHAR    = 0;
   localparam int K_AC      = 1;
   localparam int K_BUSY    = 2;
   localparam int K_FLAGS   = 3;
   localparam int K_ERRCNT  = 4;
   localparam int K_DBOUT   = 5;
   localparam int K_DBOE    = 6;
   localparam int K_BUSYRUN = 7;

   typedef struct {
      string      name;
      int         kind;
      logic [7:0] exp;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] rd_idx;
   logic [7:0] rd_char;
   logic [6:0] ac;
   logic       busy;
   logic       disp_on, cursor_on, blink_on, two_line;
   logic       err_busy;

   lcd_panel_model_if bus();

   lcd_panel_model #(
      .BUSY_CYCLES(BUSY_CYCLES),
      .BUSY_LONG  (BUSY_LONG)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus.slave),
      .rd_idx   (rd_idx),
      .rd_char  (rd_char),
      .ac       (ac),
      .busy     (busy),
      .disp_on  (disp_on),
      .cursor_on(cursor_on),
      .blink_on (blink_on),
      .two_line (two_line),
      .err_busy (err_busy)
   );

   always #5 clk = ~clk;

   exp_t sb[$];
   int   checks        = 0;
   int   errors        = 0;
   int   err_count     = 0;
   int   busy_run      = 0;
   int   last_busy_run = 0;

   // Monitor: tracks busy/err activity and drains the scoreboard on falling edges
   always @(negedge clk) begin : monitor
      exp_t       e;
      logic [7:0] act;
      if (busy) busy_run++;
      else if (busy_run != 0) begin
         last_busy_run = busy_run;
         busy_run      = 0;
      end
      if (err_busy) err_count++;
      while (sb.size() != 0) begin
         e = sb.pop_front();
         case (e.kind)
            K_CHAR:    act = rd_char;
            K_AC:      act = {1'b0, ac};
            K_BUSY:    act = {7'd0, busy};
            K_FLAGS:   act = {4'd0, disp_on, cursor_on, blink_on, two_line};
            K_ERRCNT:  act = err_count[7:0];
            K_DBOUT:   act = bus.db_out;
            K_DBOE:    act = {7'd0, bus.db_oe};
            K_BUSYRUN: act = last_busy_run[7:0];
            default:   act = 8'hxx;
         endcase
         checks++;
         if (act !== e.exp) begin
            errors++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", e.name, act, e.exp);
         end
      end
   end

   task automatic expect_val(input string name, input int kind, input logic [7:0] exp);
      exp_t e;
      e.name = name;
      e.kind = kind;
      e.exp  = exp;
      sb.push_back(e);
   endtask

   task automatic expect_char(input logic [4:0] idx, input logic [7:0] exp);
      rd_idx = idx;
      expect_val($sformatf("char%0d", idx), K_CHAR, exp);
      @(posedge clk); #1;
   endtask

   task automatic wait_ready();
      int n = 0;
      while (busy && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (busy) begin
         checks++;
         errors++;
         $display("FAIL wait_ready: busy still 1 after %0d cycles, expected 0", n);
      end
   endtask

   task automatic xfer(input logic rs, input logic rw, input logic [7:0] d);
      @(posedge clk); #1;
      bus.E  = 1'b1;
      bus.RS = rs;
      bus.RW = rw;
      bus.DB = d;
      @(posedge clk); #1;
      bus.E  = 1'b0;
   endtask

   task automatic wr(input logic rs, input logic [7:0] d);
      wait_ready();
      xfer(rs, 1'b0, d);
      @(posedge clk); #1;
   endtask

   task automatic rd(input logic rs, input logic [7:0] exp);
      @(posedge clk); #1;
      bus.E  = 1'b1;
      bus.RS = rs;
      bus.RW = 1'b1;
      bus.DB = 8'h00;
      expect_val("db_oe_read", K_DBOE, 8'h01);
      expect_val(rs ? "read_data" : "read_status", K_DBOUT, exp);
      @(posedge clk); #1;
      bus.E  = 1'b0;
      bus.RW = 1'b0;
      @(posedge clk); #1;
      expect_val("db_oe_idle", K_DBOE, 8'h00);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset  = 1'b0;
      rd_idx = 5'd0;
      bus.E  = 1'b0;
      bus.RS = 1'b0;
      bus.RW = 1'b0;
      bus.DB = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      expect_val("rst_ac", K_AC, 8'h00);
      expect_val("rst_busy", K_BUSY, 8'h00);
      expect_val("rst_flags", K_FLAGS, 8'h00);
      expect_val("rst_db_oe", K_DBOE, 8'h00);
      expect_char(5'd0, 8'h20);
      expect_char(5'd31, 8'h20);
      reset = 1'b1;
      @(posedge clk); #1;

      // Init sequence
      wr(1'b0, 8'h38);
      wr(1'b0, 8'h0F);
      wr(1'b0, 8'h0E);
      wr(1'b0, 8'h06);
      expect_val("init_flags", K_FLAGS, 8'h0D);
      expect_val("init_ac", K_AC, 8'h00);
      expect_val("init_err", K_ERRCNT, 8'h00);

      // Line 1 and line 2 writes
      wr(1'b0, 8'h80);
      wr(1'b1, 8'h48);
      wr(1'b1, 8'h49);
      expect_val("ac_after_hi", K_AC, 8'h02);
      expect_char(5'd0, 8'h48);
      expect_char(5'd1, 8'h49);
      wr(1'b0, 8'hC0);
      wr(1'b1, 8'h5A);
      expect_val("ac_line2", K_AC, 8'h41);
      expect_char(5'd16, 8'h5A);

      // Hidden address 0x27 then wrap to line 2
      wr(1'b0, 8'hA7);
      wr(1'b1, 8'h41);
      expect_val("ac_wrap_27", K_AC, 8'h40);
      wr(1'b1, 8'h42);
      expect_val("ac_after_wrap", K_AC, 8'h41);
      expect_char(5'd16, 8'h42);
      expect_char(5'd17, 8'h20);

      // Cursor shifts and decrement wrap
      wr(1'b0, 8'h10);
      wr(1'b0, 8'h10);
      expect_val("shift_dec_40", K_AC, 8'h27);
      wr(1'b0, 8'h14);
      expect_val("shift_inc_27", K_AC, 8'h40);
      wr(1'b0, 8'h04);
      wr(1'b0, 8'h80);
      wr(1'b1, 8'h55);
      expect_val("dec_wrap_00", K_AC, 8'h67);
      expect_char(5'd0, 8'h55);
      wr(1'b0, 8'h06);
      wr(1'b0, 8'hE7);
      wr(1'b0, 8'h14);
      expect_val("inc_wrap_67", K_AC, 8'h00);

      // Data read steps ac; status read reports ac
      wr(1'b0, 8'h80);
      rd(1'b1, 8'h55);
      expect_val("ac_after_read", K_AC, 8'h01);
      wait_ready();
      rd(1'b0, 8'h01);

      // Write while busy is dropped
      wr(1'b0, 8'h82);
      wait_ready();
      xfer(1'b1, 1'b0, 8'h61);
      xfer(1'b1, 1'b0, 8'h62);
      rd(1'b0, 8'h83);
      wait_ready();
      expect_val("err_pulses", K_ERRCNT, 8'h01);
      expect_val("ac_after_drop", K_AC, 8'h03);
      expect_char(5'd2, 8'h61);
      expect_char(5'd3, 8'h20);

      // Line ends, then clear display
      wr(1'b0, 8'h8F);
      wr(1'b1, 8'h7E);
      expect_val("ac_after_0f", K_AC, 8'h10);
      expect_char(5'd15, 8'h7E);
      wr(1'b0, 8'hCF);
      wr(1'b1, 8'h7F);
      expect_val("ac_after_4f", K_AC, 8'h50);
      expect_char(5'd31, 8'h7F);
      wr(1'b0, 8'h01);
      expect_val("clear_busy", K_BUSY, 8'h01);
      wait_ready();
      expect_val("clear_busy_len", K_BUSYRUN, 8'(BUSY_LONG));
      expect_val("clear_ac", K_AC, 8'h00);
      for (int i = 0; i < 32; i++) expect_char(5'(i), 8'h20);

      // Reset in the middle of an E-high read
      wr(1'b0, 8'h0F);
      wr(1'b1, 8'h33);
      expect_val("pre_rst_flags", K_FLAGS, 8'h0F);
      expect_char(5'd0, 8'h33);
      wait_ready();
      @(posedge clk); #1;
      bus.E  = 1'b1;
      bus.RS = 1'b0;
      bus.RW = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      rd_idx = 5'd0;
      expect_val("mid_rst_db_oe", K_DBOE, 8'h00);
      expect_val("mid_rst_db_out", K_DBOUT, 8'h00);
      expect_val("mid_rst_ac", K_AC, 8'h00);
      expect_val("mid_rst_flags", K_FLAGS, 8'h00);
      expect_val("mid_rst_busy", K_BUSY, 8'h00);
      expect_char(5'd0, 8'h20);
      bus.E  = 1'b0;
      bus.RW = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      expect_val("post_rst_ac", K_AC, 8'h00);
      expect_val("post_rst_err", K_ERRCNT, 8'h01);

`ifdef LCD_NIBBLE_EN
      // 4-bit mode: a byte needs two falls
      wr(1'b0, 8'h28);
      expect_val("nib_flags", K_FLAGS, 8'h01);
      wait_ready();
      xfer(1'b1, 1'b0, 8'h40);
      @(posedge clk); #1;
      expect_val("nib_first_ac", K_AC, 8'h00);
      expect_char(5'd0, 8'h20);
      xfer(1'b1, 1'b0, 8'h10);
      @(posedge clk); #1;
      expect_val("nib_second_ac", K_AC, 8'h01);
      expect_char(5'd0, 8'h41);
`endif

      for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d checks left pending, expected 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/lcd_panel_model.md
Name: lcd_panel_model

Overview:
Synthesizable responder model of an HD44780-style character LCD controller: the panel end of the E/RS/RW/DB write bus driven by the team's LCD driver block. Decodes instructions and data on each falling edge of E and maintains a 2x16 visible DDRAM image plus display-control flags. Supports busy-flag/address reads. Exposes the image through a read port for on-board mirroring (VGA/7-seg) and for self-checking benches.

Parameters:
BUSY_CYCLES, 1, clk cycles busy after any accepted write except clear/home (0 = never busy)
BUSY_LONG, 1, clk cycles busy after clear display (0x01) or return home (0x02/0x03)

Ports:
clk  input  1  master clock (50 MHz)
reset  input  1  asynchronous, active-low reset
E  input  1  enable strobe; transfer commits on falling edge
RS  input  1  0 = instruction/status, 1 = data
RW  input  1  0 = write, 1 = read
DB  input  8  write data bus
db_out  output  8  read data, valid while db_oe=1
db_oe  output  1  high while E=1 and RW=1
rd_idx  input  5  display cell index: 0-15 line 1, 16-31 line 2
rd_char  output  8  character at rd_idx (combinational)
ac  output  7  address counter
busy  output  1  busy flag
disp_on, cursor_on, blink_on, two_line  output  1 each  display-control/function-set flags
err_busy  output  1  one-cycle pulse: write arrived while busy (write dropped)

Behaviour:
- Reset (async, active-low): all 32 cells 0x20; ac=0; I/D=1; DL=1; disp_on/cursor_on/blink_on/two_line=0; busy=0; err_busy=0; db_oe=0; db_out=0; nibble phase=0; busy counter=0.
- Capture: rs_q/rw_q/db_q load RS/RW/DB on every clk edge where E=1. e_q = E delayed one clk. Fall = e_q & ~E; commit at that clk edge using the captured values. One transfer per fall. Min spacing: E high 1 clk, low 1 clk.
- busy = (busy counter != 0); counter decrements each clk until zero; loaded on commit of an accepted write.
- Write while busy: dropped, no state change, err_busy=1 for one clk. Reads are never dropped.
- Instruction decode, RS=0 RW=0, priority by highest set bit:
  1xxxxxxx set DDRAM addr: ac=DB[6:0].
  01xxxxxx CGRAM addr: accepted, no effect.
  001DNFxx function set: DL=D, two_line=N; F ignored.
  0001SRxx shift: S=0 moves ac (R=1 inc, R=0 dec); S=1 no effect.
  00001DCB: disp_on=D, cursor_on=C, blink_on=B.
  000001IS entry mode: I/D=I; S ignored.
  0000001x return home: ac=0; loads BUSY_LONG.
  00000001 clear: all cells 0x20, ac=0, I/D=1; loads BUSY_LONG.
  00000000: no-op, not busy.
- Data write (RS=1 RW=0): if ac in 0x00-0x0F, cell ac; if 0x40-0x4F, cell 16+(ac-0x40); otherwise not stored. ac then steps per I/D.
- ac step: inc: 0x27->0x40, 0x67->0x00, else +1 mod 128. dec: 0x00->0x67, 0x40->0x27, else -1 mod 128.
- Reads, while E=1: RS=0 gives db_out={busy,ac}; RS=1 gives the cell at ac (0x20 if ac is not visible). ac steps on the fall after a data read only.
- Simultaneous: the commit takes effect before the counter decrement in the same clk. Reset mid-transfer discards the captured values.

Optional Feature:
LCD_NIBBLE_EN: when defined and DL=0, each transfer is two E falls on DB[7:4], high nibble first. The first fall stores the nibble and toggles phase. The second fall assembles the byte and commits it. Busy is checked on the second fall only. A function set with DL=1, or reset, clears phase. When undefined, DL is stored but ignored and all transfers are 8-bit.

Test Plan:
- Init writes 0x38,0x0F,0x0E,0x06 at 2-clk E spacing -> two_line=1, disp_on=1, cursor_on=1, blink_on=0, ac=0x00, no err_busy.
- 0x80, data 0x48, 0x49 -> rd_idx 0 gives 0x48, rd_idx 1 gives 0x49, ac=0x02; 0xC0, data 0x5A -> rd_idx 16 gives 0x5A, ac=0x41.
- 0xA7, data 0x41, data 0x42 -> 0x41 not stored, ac 0x27->0x40, rd_idx 16 gives 0x42, ac=0x41.
- BUSY_CYCLES=4: two data writes 2 clks apart -> second dropped, err_busy pulses once; status read (RS=0 RW=1) -> db_out[7]=1, db_oe=1 while E=1.
- Fill cells, then write 0x01 -> all 32 rd_char=0x20, ac=0, busy held BUSY_LONG cycles; assert reset during a later E-high -> all outputs return to reset values.
- LCD_NIBBLE_EN: 0x28 then nibbles 4,1 with RS=1 at ac=0 -> rd_idx 0 gives 0x41 after the second fall only.
